hash_arbiter: RTL and testbench

Shares a single Hash_light_top core between NREQ requesters. The block round-robin arbitrates requests, latches the winner's 4-byte message into a holding register, and pulses the core's start. It then waits for done, with a timeout, and returns the 4-byte digest tagged with the requester index. The holding register keeps the core's message input stable for the whole computation, so requesters may change their message inputs as soon as they are granted.

---
 rtl/hash_arb_pkg.sv | 36 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/hash_arbiter.sv | 131 +++++++++++++
 tb/tb_hash_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hash_arb_pkg.sv
// Shared types for the hash core arbiter: byte/message containers and FSM states.
// Purely declarative; no latency or flow control of its own.
package hash_arb_pkg;

    localparam int BYTE_W    = 8;
    localparam int MSG_BYTES = 4;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t [0:MSG_BYTES-1] msg_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT,
        RESP
    } arb_state_t;

    // Flat bus byte k sits at bits [8k +: 8]; msg_t element k is byte k.
    function automatic msg_t word_to_msg(input logic [MSG_BYTES*BYTE_W-1:0] w);
        msg_t m;
        for (int k = 0; k < MSG_BYTES; k++) begin
            m[k] = w[k*BYTE_W +: BYTE_W];
        end
        return m;
    endfunction

    function automatic logic [MSG_BYTES*BYTE_W-1:0] msg_to_word(input msg_t m);
        logic [MSG_BYTES*BYTE_W-1:0] w;
        for (int k = 0; k < MSG_BYTES; k++) begin
            w[k*BYTE_W +: BYTE_W] = m[k];
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select: first requester at or after ptr+1, wrapping.
// Purely combinational, zero latency; no flow control (grant is advisory to the caller).
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    int              cand;
    logic            hit;
    logic [IDW-1:0]  idx;

    // Scan farthest-to-nearest so the closest requester after ptr overwrites last.
    always_comb begin
        cand = 0;
        hit  = 1'b0;
        idx  = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = (int'(ptr_i) + off) % NREQ;
            if (req_i[cand]) begin
                hit = 1'b1;
                idx = cand[IDW-1:0];
            end
        end
    end

    assign idx_o = idx;
    assign gnt_o = hit ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/hash_arbiter.sv
// Shares one hash core among NREQ requesters: grant t+1, start t+2, response one cycle after done.
// Requesters hold req_i until granted; the core's done is honoured only in WAIT, with a timeout.
module hash_arbiter
    import hash_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*32-1:0] msg_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              rsp_valid_o,
    output logic [IDW-1:0]    rsp_id_o,
    output logic [31:0]       rsp_digest_o,
    output logic              rsp_err_o,
    output logic              busy_o,
    output logic              core_start_o,
    output msg_t              core_m_o,
    input  msg_t              core_d_i,
    input  logic              core_done_i
);

    localparam int CNT_W = 16;

    arb_state_t       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    msg_t             msg_q, msg_d;
    msg_t             dig_q, dig_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NREQ-1:0]  arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic [31:0]      sel_word;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (id_q == IDW'(i)) begin
                sel_word = msg_i[i*32 +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        msg_d   = msg_q;
        dig_d   = dig_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            // Winner is frozen here so later req_i changes cannot retarget the job.
            IDLE: begin
                if (|arb_gnt) begin
                    id_d    = arb_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                msg_d   = word_to_msg(sel_word);
                ptr_d   = id_q;
                state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (core_done_i) begin
                    dig_d   = core_d_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    dig_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            msg_q   <= '0;
            dig_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            msg_q   <= msg_d;
            dig_q   <= dig_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt_o        = (state_q == GRANT) ? (NREQ'(1) << id_q) : '0;
    assign core_start_o = (state_q == START);
    assign busy_o       = (state_q != IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_id_o     = rsp_valid_o ? id_q : '0;
    assign rsp_digest_o = rsp_valid_o ? msg_to_word(dig_q) : '0;
    assign rsp_err_o    = rsp_valid_o & err_q;
    assign core_m_o     = msg_q;

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter with a stub core (digest = ~m, done 10 cycles after start).
module tb_hash_arbiter;
    import hash_arb_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_i;
    logic [127:0] msg_i;
    logic [3:0]   gnt_o;
    logic         rsp_valid_o;
    logic [1:0]   rsp_id_o;
    logic [31:0]  rsp_digest_o;
    logic         rsp_err_o;
    logic         busy_o;
    logic         core_start_o;
    msg_t         core_m_o;
    msg_t         core_d_i;
    logic         core_done_i;

    hash_arbiter #(.NREQ(4), .TIMEOUT(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .msg_i        (msg_i),
        .gnt_o        (gnt_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_id_o     (rsp_id_o),
        .rsp_digest_o (rsp_digest_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o),
        .core_start_o (core_start_o),
        .core_m_o     (core_m_o),
        .core_d_i     (core_d_i),
        .core_done_i  (core_done_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub core: latch ~m on start, raise done 10 cycles later and hold it.
    logic [4:0] stub_cnt;
    msg_t       stub_dig;
    logic       stub_nodone;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= '0;
            stub_dig <= '0;
        end else if (core_start_o) begin
            stub_cnt <= 5'd1;
            stub_dig <= ~core_m_o;
        end else if (stub_cnt != 5'd0 && stub_cnt != 5'd31) begin
            stub_cnt <= stub_cnt + 5'd1;
        end
    end
    assign core_d_i    = stub_dig;
    assign core_done_i = (stub_cnt >= 5'd10) && !stub_nodone;

    logic [31:0] m_flat;
    assign m_flat = core_m_o;

    typedef struct {
        logic [3:0]   req;
        logic [3:0]   req_after;
        logic [127:0] msg;
        logic [127:0] msg_after;
        logic         nodone;
        logic [3:0]   exp_gnt;
        logic [31:0]  exp_m;
        int           rsp_lat;
        logic [1:0]   exp_id;
        logic [31:0]  exp_dig;
        logic         exp_err;
    } vec_t;

    localparam logic [127:0] MSGS     = 128'h0FF0F00F_CCBBAA99_88776655_44332211;
    localparam logic [127:0] MSGS_ALT = 128'h0FF0F00F_CCBBAA99_88776655_FFFFFFFF;

    vec_t vecs[9];
    vec_t rv;
    int   n_cmp;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int m;
        int extra;
        stub_nodone = v.nodone;
        req_i       = v.req;
        msg_i       = v.msg;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (gnt_o == 4'b0 && n < 40);
        check("gnt", {28'b0, gnt_o}, {28'b0, v.exp_gnt});
        check("gnt_latency", n, 1);
        @(posedge clk); #1;
        req_i = v.req_after;
        msg_i = v.msg_after;
        check("start_pulse", {31'b0, core_start_o}, 32'd1);
        check("gnt_one_cycle", {28'b0, gnt_o}, 32'd0);
        check("busy", {31'b0, busy_o}, 32'd1);
        check("core_m", m_flat, v.exp_m);
        m = 0;
        extra = 0;
        do begin
            @(posedge clk); #1;
            m++;
            if (core_start_o) extra++;
        end while (!rsp_valid_o && m < 60);
        check("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
        check("rsp_latency", m, v.rsp_lat);
        check("rsp_id", {30'b0, rsp_id_o}, {30'b0, v.exp_id});
        check("rsp_digest", rsp_digest_o, v.exp_dig);
        check("rsp_err", {31'b0, rsp_err_o}, {31'b0, v.exp_err});
        check("core_m_hold", m_flat, v.exp_m);
        check("extra_start", extra, 0);
        @(posedge clk); #1;
        check("rsp_one_cycle", {31'b0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        req_i  = '0;
        msg_i  = '0;
        stub_nodone = 1'b0;

        vecs[0] = '{req:4'b0001, req_after:4'b0000, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b0001, exp_m:32'h11223344, rsp_lat:11, exp_id:2'd0,
                    exp_dig:32'hBBCCDDEE, exp_err:1'b0};
        vecs[1] = '{req:4'b1111, req_after:4'b1111, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b0010, exp_m:32'h55667788, rsp_lat:11, exp_id:2'd1,
                    exp_dig:32'h778899AA, exp_err:1'b0};
        vecs[2] = '{req:4'b1111, req_after:4'b1111, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b0100, exp_m:32'h99AABBCC, rsp_lat:11, exp_id:2'd2,
                    exp_dig:32'h33445566, exp_err:1'b0};
        vecs[3] = '{req:4'b1111, req_after:4'b1111, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b1000, exp_m:32'h0FF0F00F, rsp_lat:11, exp_id:2'd3,
                    exp_dig:32'hF00F0FF0, exp_err:1'b0};
        vecs[4] = '{req:4'b1111, req_after:4'b0000, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b0001, exp_m:32'h11223344, rsp_lat:11, exp_id:2'd0,
                    exp_dig:32'hBBCCDDEE, exp_err:1'b0};
        vecs[5] = '{req:4'b0001, req_after:4'b0000, msg:MSGS, msg_after:MSGS_ALT, nodone:1'b0,
                    exp_gnt:4'b0001, exp_m:32'h11223344, rsp_lat:11, exp_id:2'd0,
                    exp_dig:32'hBBCCDDEE, exp_err:1'b0};
        vecs[6] = '{req:4'b0100, req_after:4'b0000, msg:MSGS, msg_after:MSGS, nodone:1'b1,
                    exp_gnt:4'b0100, exp_m:32'h99AABBCC, rsp_lat:21, exp_id:2'd2,
                    exp_dig:32'h00000000, exp_err:1'b1};
        vecs[7] = '{req:4'b1000, req_after:4'b0000, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b1000, exp_m:32'h0FF0F00F, rsp_lat:11, exp_id:2'd3,
                    exp_dig:32'hF00F0FF0, exp_err:1'b0};
        vecs[8] = '{req:4'b0010, req_after:4'b0000, msg:MSGS, msg_after:MSGS, nodone:1'b0,
                    exp_gnt:4'b0010, exp_m:32'h55667788, rsp_lat:11, exp_id:2'd1,
                    exp_dig:32'h778899AA, exp_err:1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_gnt", {28'b0, gnt_o}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        check("rst_core_m", m_flat, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_gnt", {28'b0, gnt_o}, 32'd0);
        check("idle_start", {31'b0, core_start_o}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Reset five cycles into WAIT with a different requester pending.
        begin
            int w;
            req_i = 4'b0001;
            msg_i = MSGS;
            w = 0;
            do begin
                @(posedge clk); #1;
                w++;
            end while (!core_start_o && w < 40);
            check("mid_start_seen", {31'b0, core_start_o}, 32'd1);
            req_i = 4'b0000;
            repeat (5) @(posedge clk);
            #1;
            check("mid_busy", {31'b0, busy_o}, 32'd1);
            req_i = 4'b0100;
            rst_n = 1'b0;
            #1;
            check("mid_rst_busy", {31'b0, busy_o}, 32'd0);
            check("mid_rst_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
            check("mid_rst_core_m", m_flat, 32'd0);
            check("mid_rst_digest", rsp_digest_o, 32'd0);
            check("mid_rst_gnt", {28'b0, gnt_o}, 32'd0);
            @(posedge clk); #1;
            check("mid_rst_gnt_held", {28'b0, gnt_o}, 32'd0);
            rst_n = 1'b1;
        end
        rv = '{req:4'b0100, req_after:4'b0000, msg:MSGS, msg_after:MSGS, nodone:1'b0,
               exp_gnt:4'b0100, exp_m:32'h99AABBCC, rsp_lat:11, exp_id:2'd2,
               exp_dig:32'h33445566, exp_err:1'b0};
        run_vec(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
